forward_station: RTL and testbench

- Parametrised successor to the single-channel forwarder: a DEPTH-entry buffer of (target, val, tag) records.
- Each entry waits until the ROB/CDB broadcasts the producing tag, captures the value, then issues to the writeback path.
- Adds NUM_BCAST parallel broadcast channels, insert-time bypass, oldest-first issue, a valid/ready output handshake, back-pressure and flush.
- Sits between the ID/EX stage (producer of forward requests) and the register-file writeback arbiter.

---
 rtl/fwd_pkg.sv | 34 +++
 rtl/fwd_oldest_select.sv | 43 ++++
 rtl/fwd_station_checker.sv | 18 +
 rtl/forward_station.sv | 210 +++++++++++++++++++++
 tb/tb_forward_station.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared definitions for the forwarding station and related reservation
// stations: the invalid-tag constant, the default geometry, the age-width
// helper and the per-entry record.
// The entry record is sized from the default geometry, so a station that
// stores fwd_entry_t must be instantiated with matching TAG_W/VAL_W/DEPTH.
// -----------------------------------------------------------------------------
package fwd_pkg;

    localparam int FWD_TAG_W     = 4;
    localparam int FWD_VAL_W     = 32;
    localparam int FWD_DEPTH     = 4;
    localparam int FWD_NUM_BCAST = 2;

    // Tag value 0 means "value already present, nothing to wait for".
    localparam logic [FWD_TAG_W-1:0] TAG_INVALID = {FWD_TAG_W{1'b0}};

    // Width needed to hold an age in 0..depth-1 (never narrower than 1 bit).
    function automatic int fwd_age_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int FWD_AGE_W = fwd_age_w(FWD_DEPTH);

    typedef struct packed {
        logic                 valid;
        logic [FWD_TAG_W-1:0] target;
        logic [FWD_VAL_W-1:0] val;
        logic [FWD_TAG_W-1:0] tag;
        logic [FWD_AGE_W-1:0] age;
    } fwd_entry_t;

endpackage

// File: rtl/fwd_oldest_select.sv
// -----------------------------------------------------------------------------
// fwd_oldest_select
// Combinational picker: among the entries flagged ready, returns the index of
// the one with the largest age (the oldest). Ages of valid entries are
// distinct, so there is never a tie to break.
// Ports:
//   ready [N]        per-entry ready flags
//   age   [N*AGE_W]  packed per-entry ages, entry 0 in the LSBs
//   found            at least one entry is ready
//   idx              index of the oldest ready entry (0 when !found)
// -----------------------------------------------------------------------------
module fwd_oldest_select #(
    parameter int N     = 4,
    parameter int AGE_W = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]       ready,
    input  logic [N*AGE_W-1:0] age,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [AGE_W-1:0] best_age_s;
    logic [AGE_W-1:0] cur_age_s;
    logic             take_s;

    // Linear scan keeping the best (oldest) ready candidate seen so far
    always_comb begin
        found      = 1'b0;
        idx        = '0;
        best_age_s = '0;
        cur_age_s  = '0;
        take_s     = 1'b0;
        for (int i = 0; i < N; i++) begin
            cur_age_s  = age[i*AGE_W +: AGE_W];
            take_s     = ready[i] && (!found || (cur_age_s > best_age_s));
            found      = found | take_s;
            idx        = take_s ? IDX_W'(i) : idx;
            best_age_s = take_s ? cur_age_s : best_age_s;
        end
    end

endmodule

// File: rtl/fwd_station_checker.sv
// -----------------------------------------------------------------------------
// fwd_station_checker
// Simulation-only observer for forward_station. Reports insert requests
// presented while the station is full; the station drops those requests.
// Ports: clk, rst, in_valid, in_ready (all observed, none driven).
// -----------------------------------------------------------------------------
module fwd_station_checker (
    input logic clk,
    input logic rst,
    input logic in_valid,
    input logic in_ready
);

    // An insert offered without space is lost; the producer should not do this
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(in_valid && !in_ready))
        else $warning("forward_station: insert offered while full was dropped");

endmodule

// File: rtl/forward_station.sv
// -----------------------------------------------------------------------------
// forward_station
// DEPTH-entry buffer of (target, val, tag) records between ID/EX and the
// register-file writeback arbiter. Entries wait for their producing tag on any
// of NUM_BCAST broadcast channels, capture the value, and are issued
// oldest-first through a registered valid/ready output.
// Ports:
//   clk, rst (async, active-high), flush (sync clear)
//   in_valid/in_ready/in_target/in_val/in_tag   insert side
//   bc_valid/bc_tag/bc_val                      packed broadcast channels
//   out_valid/out_ready/out_target/out_val      registered issue side
//   count                                       occupied entries
// -----------------------------------------------------------------------------
module forward_station
    import fwd_pkg::*;
#(
    parameter int TAG_W     = FWD_TAG_W,
    parameter int VAL_W     = FWD_VAL_W,
    parameter int DEPTH     = FWD_DEPTH,
    parameter int NUM_BCAST = FWD_NUM_BCAST,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TAG_W-1:0]           in_target,
    input  logic [VAL_W-1:0]           in_val,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic [NUM_BCAST-1:0]       bc_valid,
    input  logic [NUM_BCAST*TAG_W-1:0] bc_tag,
    input  logic [NUM_BCAST*VAL_W-1:0] bc_val,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TAG_W-1:0]           out_target,
    output logic [VAL_W-1:0]           out_val,
    output logic [CNT_W-1:0]           count
);

    localparam int AGE_W = fwd_age_w(DEPTH);
    localparam int IDX_W = AGE_W;

    fwd_entry_t       ent_r      [DEPTH];
    fwd_entry_t       ent_next_s [DEPTH];
    logic [VAL_W:0]   wake_s     [DEPTH];   // {hit, value}
    logic [VAL_W:0]   ins_wake_s;
    logic [DEPTH-1:0] rdy_s;
    logic [DEPTH*AGE_W-1:0] age_vec_s;
    logic             found_s;
    logic [IDX_W-1:0] sel_idx_s;
    logic [AGE_W-1:0] sel_age_s;
    logic [IDX_W-1:0] free_idx_s;
    logic             out_free_s;
    logic             issue_s;
    logic             insert_s;
    logic             out_valid_r;
    logic [TAG_W-1:0] out_target_r;
    logic [VAL_W-1:0] out_val_r;
    logic [CNT_W-1:0] count_r;

    // Search all channels for a tag; the lowest-index matching channel wins.
    function automatic logic [VAL_W:0] bc_lookup(
        input logic [TAG_W-1:0]           tag,
        input logic [NUM_BCAST-1:0]       v,
        input logic [NUM_BCAST*TAG_W-1:0] t,
        input logic [NUM_BCAST*VAL_W-1:0] d
    );
        logic [VAL_W:0] res;
        res = '0;
        for (int c = NUM_BCAST - 1; c >= 0; c--) begin
            res = (v[c] && (tag != TAG_INVALID) && (t[c*TAG_W +: TAG_W] == tag))
                ? {1'b1, d[c*VAL_W +: VAL_W]} : res;
        end
        return res;
    endfunction

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready   = (count_r < CNT_W'(DEPTH));
    assign out_free_s = !out_valid_r || out_ready;
    assign issue_s    = out_free_s && found_s;
    assign insert_s   = in_valid && in_ready && (in_target != TAG_INVALID);
    assign sel_age_s  = ent_r[sel_idx_s].age;

    assign out_valid  = out_valid_r;
    assign out_target = out_target_r;
    assign out_val    = out_val_r;
    assign count      = count_r;

    // Broadcast matches per entry and for the incoming request; eligibility
    always_comb begin
        ins_wake_s = bc_lookup(in_tag, bc_valid, bc_tag, bc_val);
        for (int i = 0; i < DEPTH; i++) begin
            wake_s[i] = bc_lookup(ent_r[i].tag, bc_valid, bc_tag, bc_val);
            rdy_s[i]  = ent_r[i].valid && (ent_r[i].tag == TAG_INVALID);
            age_vec_s[i*AGE_W +: AGE_W] = ent_r[i].age;
        end
    end

    // Lowest-index free slot in the pre-edge state
    always_comb begin
        free_idx_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_r[i].valid) begin
                free_idx_s = IDX_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
    end

    fwd_oldest_select #(
        .N     (DEPTH),
        .AGE_W (AGE_W),
        .IDX_W (IDX_W)
    ) u_select (
        .ready (rdy_s),
        .age   (age_vec_s),
        .found (found_s),
        .idx   (sel_idx_s)
    );

    // Next entry state: free on issue, wake/age on survive, fill on insert
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_next_s[i] = ent_r[i];
            if (issue_s && (sel_idx_s == IDX_W'(i))) begin
                ent_next_s[i] = '0;
            end else if (ent_r[i].valid) begin
                if (wake_s[i][VAL_W]) begin
                    ent_next_s[i].val = wake_s[i][VAL_W-1:0];
                    ent_next_s[i].tag = TAG_INVALID;
                end else begin
                    ent_next_s[i].val = ent_r[i].val;
                end
                // Older than the removed entry: close the gap; insert: shift up
                ent_next_s[i].age = ent_r[i].age
                    - ((issue_s && (ent_r[i].age > sel_age_s)) ? AGE_W'(1'b1) : AGE_W'(1'b0))
                    + (insert_s ? AGE_W'(1'b1) : AGE_W'(1'b0));
            end else if (insert_s && (free_idx_s == IDX_W'(i))) begin
                ent_next_s[i].valid  = 1'b1;
                ent_next_s[i].target = in_target;
                ent_next_s[i].val    = ins_wake_s[VAL_W] ? ins_wake_s[VAL_W-1:0] : in_val;
                ent_next_s[i].tag    = ins_wake_s[VAL_W] ? TAG_INVALID : in_tag;
                ent_next_s[i].age    = '0;
            end else begin
                ent_next_s[i] = ent_r[i];
            end
        end
    end

    // Entry storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i] <= ent_next_s[i];
            end
        end
    end

    // Output register: loads when empty or consumed, holds under back-pressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_target_r <= TAG_INVALID;
            out_val_r    <= '0;
        end else if (flush) begin
            out_valid_r  <= 1'b0;
            out_target_r <= TAG_INVALID;
            out_val_r    <= '0;
        end else if (out_free_s) begin
            if (found_s) begin
                out_valid_r  <= 1'b1;
                out_target_r <= ent_r[sel_idx_s].target;
                out_val_r    <= ent_r[sel_idx_s].val;
            end else begin
                out_valid_r  <= 1'b0;
            end
        end else begin
            out_valid_r  <= out_valid_r;
        end
    end

    // Occupancy counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (flush) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(insert_s) - CNT_W'(issue_s);
        end
    end

    fwd_station_checker u_checker (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready)
    );

endmodule

// File: tb/tb_forward_station.sv
// -----------------------------------------------------------------------------
// tb_forward_station
// Directed table of vectors plus randomized traffic, all checked against an
// insertion-ordered queue model of the station.
// -----------------------------------------------------------------------------
module tb_forward_station;

    localparam int DEPTH = 4;
    localparam int NB    = 2;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  in_target, in_tag, out_target;
    logic [31:0] in_val, out_val;
    logic [1:0]  bc_valid;
    logic [3:0]  bc_tag_a [NB];
    logic [31:0] bc_val_a [NB];
    logic [7:0]  bc_tag;
    logic [63:0] bc_val;
    logic [2:0]  count;

    assign bc_tag = {bc_tag_a[1], bc_tag_a[0]};
    assign bc_val = {bc_val_a[1], bc_val_a[0]};

    always #5 clk = ~clk;

    forward_station #(.TAG_W(4), .VAL_W(32), .DEPTH(DEPTH), .NUM_BCAST(NB)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_target(in_target),
        .in_val(in_val), .in_tag(in_tag),
        .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_val(bc_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_target(out_target),
        .out_val(out_val), .count(count)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: queue in insertion order -------------
    typedef struct {
        logic [3:0]  target;
        logic [31:0] val;
        logic [3:0]  tag;
    } ment_t;

    ment_t       mq[$];
    logic        m_ov   = 1'b0;
    logic [3:0]  m_ot   = 4'd0;
    logic [31:0] m_oval = 32'd0;

    task automatic bc_find(input logic [3:0] t, output logic hit, output logic [31:0] v);
        hit = 1'b0;
        v   = 32'd0;
        for (int c = 0; c < NB; c++) begin
            if (!hit && t != 4'd0 && bc_valid[c] && bc_tag_a[c] == t) begin
                hit = 1'b1;
                v   = bc_val_a[c];
            end
        end
    endtask

    task automatic model_edge();
        int          sel;
        logic        hit, accept;
        logic [31:0] v;
        ment_t       e;
        if (flush) begin
            mq.delete();
            m_ov = 1'b0; m_ot = 4'd0; m_oval = 32'd0;
            return;
        end
        accept = in_valid && (mq.size() < DEPTH) && (in_target != 4'd0);
        sel = -1;
        if (!m_ov || out_ready) begin
            for (int i = 0; i < mq.size(); i++)
                if (sel < 0 && mq[i].tag == 4'd0) sel = i;
            if (sel >= 0) begin
                m_ov = 1'b1; m_ot = mq[sel].target; m_oval = mq[sel].val;
            end else begin
                m_ov = 1'b0;
            end
        end
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            if (e.tag != 4'd0) begin
                bc_find(e.tag, hit, v);
                if (hit) begin e.val = v; e.tag = 4'd0; end
                mq[i] = e;
            end
        end
        if (sel >= 0) mq.delete(sel);
        if (accept) begin
            e.target = in_target; e.tag = in_tag; e.val = in_val;
            bc_find(in_tag, hit, v);
            if (hit) begin e.val = v; e.tag = 4'd0; end
            mq.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("count", 32'(count), 32'(mq.size()));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_target", 32'(out_target), 32'(m_ot));
            chk("out_val", out_val, m_oval);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_target = 4'd0; in_tag = 4'd0; in_val = 32'd0;
        bc_valid = 2'b00; flush = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < NB; c++) begin bc_tag_a[c] = 4'd0; bc_val_a[c] = 32'd0; end
    endtask

    // ---------------- directed vector table ---------------------------------
    typedef struct {
        logic iv; logic [3:0] it; logic [3:0] itag; logic [31:0] ival;
        logic [1:0] bv; logic [3:0] bt0; logic [31:0] bd0; logic [3:0] bt1; logic [31:0] bd1;
        logic ordy; logic fl;
        logic e_ov; logic [3:0] e_ot; logic [31:0] e_oval; logic [2:0] e_cnt; logic e_rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(
        input logic iv, input logic [3:0] it, input logic [3:0] itag, input logic [31:0] ival,
        input logic [1:0] bv, input logic [3:0] bt0, input logic [31:0] bd0,
        input logic [3:0] bt1, input logic [31:0] bd1, input logic ordy, input logic fl,
        input logic e_ov, input logic [3:0] e_ot, input logic [31:0] e_oval,
        input logic [2:0] e_cnt, input logic e_rdy);
        vec_t r;
        r.iv = iv; r.it = it; r.itag = itag; r.ival = ival;
        r.bv = bv; r.bt0 = bt0; r.bd0 = bd0; r.bt1 = bt1; r.bd1 = bd1;
        r.ordy = ordy; r.fl = fl;
        r.e_ov = e_ov; r.e_ot = e_ot; r.e_oval = e_oval; r.e_cnt = e_cnt; r.e_rdy = e_rdy;
        tbl.push_back(r);
    endfunction

    initial begin
        // ready insert, then issue
        add(1'b1, 4'd5, 4'd0, 32'hAA, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 3'd1, 1'b1);
        add(1'b0, 4'd0, 4'd0, 32'd0,  2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b1, 4'd5, 32'hAA, 3'd0, 1'b1);
        add(1'b0, 4'd0, 4'd0, 32'd0,  2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 3'd0, 1'b1);
        // wakeup on channel 1
        add(1'b1, 4'd3, 4'd7, 32'd0,  2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 3'd1, 1'b1);
        add(1'b0, 4'd0, 4'd0, 32'd0,  2'b10, 4'd0, 32'd0, 4'd7, 32'h1234, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 3'd1, 1'b1);
        add(1'b0, 4'd0, 4'd0, 32'd0,  2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b1, 4'd3, 32'h1234, 3'd0, 1'b1);
        // both channels match: channel 0 wins
        add(1'b1, 4'd3, 4'd7, 32'd0,  2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 3'd1, 1'b1);
        add(1'b0, 4'd0, 4'd0, 32'd0,  2'b11, 4'd7, 32'h11, 4'd7, 32'h22, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 3'd1, 1'b1);
        add(1'b0, 4'd0, 4'd0, 32'd0,  2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b1, 4'd3, 32'h11, 3'd0, 1'b1);
        // insert bypass
        add(1'b1, 4'd4, 4'd9, 32'd0,  2'b01, 4'd9, 32'h55, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 3'd1, 1'b1);
        add(1'b0, 4'd0, 4'd0, 32'd0,  2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b1, 4'd4, 32'h55, 3'd0, 1'b1);
        // oldest-first with back-pressure
        add(1'b1, 4'd1, 4'd4, 32'd0,  2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 3'd1, 1'b1);
        add(1'b1, 4'd2, 4'd5, 32'd0,  2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 3'd2, 1'b1);
        add(1'b1, 4'd3, 4'd6, 32'd0,  2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 3'd3, 1'b1);
        add(1'b0, 4'd0, 4'd0, 32'd0,  2'b11, 4'd4, 32'h104, 4'd5, 32'h105, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 3'd3, 1'b1);
        add(1'b0, 4'd0, 4'd0, 32'd0,  2'b01, 4'd6, 32'h106, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1, 4'd1, 32'h104, 3'd2, 1'b1);
        add(1'b0, 4'd0, 4'd0, 32'd0,  2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1, 4'd1, 32'h104, 3'd2, 1'b1);
        add(1'b0, 4'd0, 4'd0, 32'd0,  2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1, 4'd1, 32'h104, 3'd2, 1'b1);
        add(1'b0, 4'd0, 4'd0, 32'd0,  2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b1, 4'd2, 32'h105, 3'd1, 1'b1);
        add(1'b0, 4'd0, 4'd0, 32'd0,  2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b1, 4'd3, 32'h106, 3'd0, 1'b1);
        add(1'b0, 4'd0, 4'd0, 32'd0,  2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 3'd0, 1'b1);
        // fill, overflow, issue while full
        add(1'b1, 4'd1, 4'd8, 32'd0,  2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 3'd1, 1'b1);
        add(1'b1, 4'd2, 4'd9, 32'd0,  2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 3'd2, 1'b1);
        add(1'b1, 4'd3, 4'd10, 32'd0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 3'd3, 1'b1);
        add(1'b1, 4'd4, 4'd11, 32'd0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 3'd4, 1'b0);
        add(1'b1, 4'd5, 4'd12, 32'd0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 3'd4, 1'b0);
        add(1'b0, 4'd0, 4'd0, 32'd0,  2'b01, 4'd8, 32'h88, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 3'd4, 1'b0);
        add(1'b1, 4'd6, 4'd0, 32'h66, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b1, 4'd1, 32'h88, 3'd3, 1'b1);
        // back-pressured output, then flush with insert and broadcast ignored
        add(1'b0, 4'd0, 4'd0, 32'd0,  2'b01, 4'd9, 32'h99, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1, 4'd1, 32'h88, 3'd3, 1'b1);
        add(1'b1, 4'd7, 4'd0, 32'h77, 2'b01, 4'd10, 32'h10, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 3'd0, 1'b1);
        add(1'b0, 4'd0, 4'd0, 32'd0,  2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 3'd0, 1'b1);

        // ---------------- reset state ----------------
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_target", 32'(out_target), 32'd0);
        chk("reset out_val", out_val, 32'd0);
        chk("reset count", 32'(count), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // ---------------- table ----------------
        for (int k = 0; k < tbl.size(); k++) begin
            in_valid = tbl[k].iv; in_target = tbl[k].it; in_tag = tbl[k].itag; in_val = tbl[k].ival;
            bc_valid = tbl[k].bv;
            bc_tag_a[0] = tbl[k].bt0; bc_val_a[0] = tbl[k].bd0;
            bc_tag_a[1] = tbl[k].bt1; bc_val_a[1] = tbl[k].bd1;
            out_ready = tbl[k].ordy; flush = tbl[k].fl;
            tick();
            chk($sformatf("row%0d out_valid", k), 32'(out_valid), 32'(tbl[k].e_ov));
            if (tbl[k].e_ov) begin
                chk($sformatf("row%0d out_target", k), 32'(out_target), 32'(tbl[k].e_ot));
                chk($sformatf("row%0d out_val", k), out_val, tbl[k].e_oval);
            end
            chk($sformatf("row%0d count", k), 32'(count), 32'(tbl[k].e_cnt));
            chk($sformatf("row%0d in_ready", k), 32'(in_ready), 32'(tbl[k].e_rdy));
        end

        // ---------------- async reset mid-wakeup ----------------
        idle_inputs();
        in_valid = 1'b1; in_target = 4'd1; in_tag = 4'd3; out_ready = 1'b0;
        tick();
        in_target = 4'd2; in_tag = 4'd0; in_val = 32'h22;
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_rst out_valid", 32'(out_valid), 32'd1);
        chk("pre_rst count", 32'(count), 32'd1);
        bc_valid = 2'b01; bc_tag_a[0] = 4'd3; bc_val_a[0] = 32'h33;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst out_valid", 32'(out_valid), 32'd0);
        chk("async_rst out_target", 32'(out_target), 32'd0);
        chk("async_rst out_val", out_val, 32'd0);
        chk("async_rst count", 32'(count), 32'd0);
        chk("async_rst in_ready", 32'(in_ready), 32'd1);
        mq.delete(); m_ov = 1'b0; m_ot = 4'd0; m_oval = 32'd0;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        tick();

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 1500; n++) begin
            in_valid  = ($urandom_range(0, 2) != 0) && (mq.size() < DEPTH);
            in_target = 4'($urandom_range(0, 15));
            in_tag    = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 7));
            in_val    = $urandom;
            for (int c = 0; c < NB; c++) begin
                bc_valid[c] = 1'($urandom_range(0, 1));
                bc_tag_a[c] = 4'($urandom_range(0, 7));
                bc_val_a[c] = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
